// File: rtl/lstm_gate_preact_mac.sv
// LSTM gate pre-activation MAC: y = bias + sum(x[k]*w[k]) in Q6.11, one operand pair per cycle.
// The result is rounded half-up, saturated to 18 bits and held until the consumer takes it.
module lstm_gate_preact_mac #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] x_in,
    input  logic [17:0] w_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] y,
    output logic        sat,
    output logic        busy
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-131072);

    generate
        if (N_TERMS < 1 || ACC_W < 36 + $clog2(N_TERMS) + 1) begin : g_bad_params
            $error("lstm_gate_preact_mac: N_TERMS must be >= 1 and ACC_W >= 37 + clog2(N_TERMS)");
        end
    endgenerate

    // Handshakes: a pair moves when in_valid && in_ready; a result moves when out_valid && out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

    state_t                   state;
    state_t                   state_next;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic signed [35:0]       prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  r;
    logic        [17:0]       y_next;
    logic                     sat_next;
    logic                     take;
    logic                     last;

    assign prod    = $signed(x_in) * $signed(w_in);
    assign acc_sum = acc + {{(ACC_W-36){prod[35]}}, prod};
    assign rnd     = acc_sum + ACC_W'(1024);
    assign r       = rnd >>> 11;
    assign take    = in_valid && in_ready;
    assign last    = (cnt == CNT_W'(N_TERMS - 1));

    always_comb begin
        y_next   = r[17:0];
        sat_next = 1'b0;
        if (r > Y_MAX) begin
            y_next   = 18'h1ffff;
            sat_next = 1'b1;
        end else if (r < Y_MIN) begin
            y_next   = 18'h20000;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (take && last) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            y   <= '0;
            sat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // Bias is Q6.11; shift into the Q.22 accumulator domain.
                    acc <= {{(ACC_W-29){bias[17]}}, bias, 11'b0};
                    cnt <= '0;
                end
                ACC: if (take) begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        y   <= y_next;
                        sat <= sat_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
